gshare_predictor: RTL and testbench

Direction predictor that consumes the 4-bit global branch history and resolved branch outcomes. It holds a pattern history table (PHT) of 2-bit saturating counters indexed by PC bits XOR history, and gives the fetch stage a taken/not-taken prediction. It trains the PHT when a branch resolves in ID/EX and flags mispredictions. It sits beside the global history register: the register supplies `branch_history` for lookup, and this block is trained from the same `ID_EX_Branch`/`Pcsrc` resolution event.

---
 rtl/gshare_predictor.sv | 89 ++++++++
 tb/tb_gshare_predictor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare direction predictor: a PHT of 2-bit saturating counters indexed by
// PC bits XOR global history, trained on branch resolution, with statistics.
module gshare_predictor #(
  parameter int HIST_BITS = 4,
  parameter int PC_LSB    = 2,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          IF_PC,
  input  logic [HIST_BITS-1:0] branch_history,
  output logic                 predict_taken,
  output logic [HIST_BITS-1:0] predict_hist,
  input  logic                 ID_EX_Branch,
  input  logic [31:0]          ID_EX_PC,
  input  logic [HIST_BITS-1:0] ID_EX_hist,
  input  logic                 ID_EX_pred,
  input  logic                 Pcsrc,
  output logic                 mispredict,
  output logic [CNT_BITS-1:0]  branch_count,
  output logic [CNT_BITS-1:0]  mispredict_count
);

  localparam int DEPTH = 1 << HIST_BITS;

  logic [1:0]           pht_q [DEPTH];
  logic [1:0]           pht_d [DEPTH];
  logic [HIST_BITS-1:0] lookup_idx;
  logic [HIST_BITS-1:0] update_idx;
  logic [1:0]           update_cnt;
  logic [1:0]           trained_cnt;
  logic [1:0]           lookup_cnt;
  logic [CNT_BITS-1:0]  branch_count_q, branch_count_d;
  logic [CNT_BITS-1:0]  mispredict_count_q, mispredict_count_d;
  logic                 unused_bits;

  assign lookup_idx = IF_PC[PC_LSB+HIST_BITS-1:PC_LSB] ^ branch_history;
  assign update_idx = ID_EX_PC[PC_LSB+HIST_BITS-1:PC_LSB] ^ ID_EX_hist;

  // PC bits outside the index window do not take part in prediction.
  assign unused_bits = ^{IF_PC[31:PC_LSB+HIST_BITS], IF_PC[PC_LSB-1:0],
                         ID_EX_PC[31:PC_LSB+HIST_BITS], ID_EX_PC[PC_LSB-1:0]};

  always_comb begin
    update_cnt  = pht_q[update_idx];
    trained_cnt = update_cnt;
    if (Pcsrc) begin
      if (update_cnt != 2'b11) trained_cnt = update_cnt + 2'b01;
    end else begin
      if (update_cnt != 2'b00) trained_cnt = update_cnt - 2'b01;
    end

    pht_d = pht_q;
    if (ID_EX_Branch) pht_d[update_idx] = trained_cnt;

    // A lookup hitting the entry being trained sees the post-update value.
    if (ID_EX_Branch && (lookup_idx == update_idx)) lookup_cnt = trained_cnt;
    else                                            lookup_cnt = pht_q[lookup_idx];
  end

  assign predict_taken = lookup_cnt[1];
  assign predict_hist  = branch_history;
  assign mispredict    = ID_EX_Branch & (ID_EX_pred != Pcsrc);

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (ID_EX_Branch && (branch_count_q != '1))
      branch_count_d = branch_count_q + 1'b1;
    if (mispredict && (mispredict_count_q != '1))
      mispredict_count_d = mispredict_count_q + 1'b1;
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= 2'b01;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      pht_q              <= pht_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor; expected values are
// hand-computed from the counter encoding and index arithmetic.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ifPc;
  logic [3:0]  branchHistory;
  logic        predictTaken;
  logic [3:0]  predictHist;
  logic        exBranch;
  logic [31:0] exPc;
  logic [3:0]  exHist;
  logic        exPred;
  logic        pcSrc;
  logic        mispredict;
  logic [15:0] branchCount;
  logic [15:0] mispredictCount;

  int compareCount  = 0;
  int mismatchCount = 0;

  gshare_predictor dut (
    .clk              (clk),
    .reset            (reset),
    .IF_PC            (ifPc),
    .branch_history   (branchHistory),
    .predict_taken    (predictTaken),
    .predict_hist     (predictHist),
    .ID_EX_Branch     (exBranch),
    .ID_EX_PC         (exPc),
    .ID_EX_hist       (exHist),
    .ID_EX_pred       (exPred),
    .Pcsrc            (pcSrc),
    .mispredict       (mispredict),
    .branch_count     (branchCount),
    .mispredict_count (mispredictCount)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle's worth of inputs shortly after a rising edge and lets
  // the combinational outputs settle before any checks.
  task automatic applyStimulus(input logic br, input logic [31:0] pc, input logic [3:0] hist,
                               input logic pred, input logic outcome,
                               input logic [31:0] lookPc, input logic [3:0] lookHist);
    exBranch      = br;
    exPc          = pc;
    exHist        = hist;
    exPred        = pred;
    pcSrc         = outcome;
    ifPc          = lookPc;
    branchHistory = lookHist;
    #1;
  endtask

  // Advances to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reset-mid-operation helper: one cycle of reset with no branch activity.
  task automatic pulseReset();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    nextCycle();
    reset = 1'b0;
  endtask

  // Main directed sequence.
  initial begin
    logic [1:0] pairs [5];
    logic       expMis [5];
    pairs  = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    expMis = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
    nextCycle();
    nextCycle();
    reset = 1'b0;

    // Reset state: every entry weak not-taken.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'(i) << 2, 4'h0);
      checkOutput($sformatf("reset_pred_%0d", i), {31'b0, predictTaken}, 32'd0);
    end
    checkOutput("reset_bcount", {16'b0, branchCount}, 32'd0);
    checkOutput("reset_mcount", {16'b0, mispredictCount}, 32'd0);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'b1010);
    checkOutput("predict_hist", {28'b0, predictHist}, 32'ha);

    // Saturation on entry 4: WN->WT->ST->ST, then ST->WT->WN.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h10, 4'h0, 1'b1, 1'b1, 32'h0, 4'h0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h10, 4'h0);
      checkOutput($sformatf("sat_up_%0d", k), {31'b0, predictTaken}, 32'd1);
    end
    applyStimulus(1'b1, 32'h10, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h10, 4'h0);
    checkOutput("sat_down_wt", {31'b0, predictTaken}, 32'd1);
    applyStimulus(1'b1, 32'h10, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h10, 4'h0);
    checkOutput("sat_down_wn", {31'b0, predictTaken}, 32'd0);

    // XOR aliasing: PC 0x14 with history 3 trains index 6.
    applyStimulus(1'b1, 32'h14, 4'b0011, 1'b0, 1'b1, 32'h0, 4'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h18, 4'h0);
    checkOutput("alias_idx6", {31'b0, predictTaken}, 32'd1);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h14, 4'h0);
    checkOutput("alias_idx5", {31'b0, predictTaken}, 32'd0);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'b0110);
    checkOutput("alias_hist6", {31'b0, predictTaken}, 32'd1);

    // Same-cycle bypass with entry 4 at WN.
    applyStimulus(1'b1, 32'h10, 4'h0, 1'b0, 1'b1, 32'h10, 4'h0);
    checkOutput("bypass_hit", {31'b0, predictTaken}, 32'd1);
    applyStimulus(1'b1, 32'h10, 4'h0, 1'b0, 1'b1, 32'h1c, 4'h0);
    checkOutput("bypass_miss", {31'b0, predictTaken}, 32'd0);
    nextCycle();

    // Mispredict flag and statistics from a clean start.
    pulseReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'h40, 4'h0, pairs[k][1], pairs[k][0], 32'h0, 4'h0);
      checkOutput($sformatf("mispredict_%0d", k + 1), {31'b0, mispredict}, {31'b0, expMis[k]});
      nextCycle();
    end
    checkOutput("bcount_5", {16'b0, branchCount}, 32'd5);
    checkOutput("mcount_3", {16'b0, mispredictCount}, 32'd3);
    applyStimulus(1'b0, 32'h40, 4'h0, 1'b1, 1'b0, 32'h0, 4'h0);
    checkOutput("mispredict_idle", {31'b0, mispredict}, 32'd0);
    nextCycle();
    checkOutput("bcount_hold", {16'b0, branchCount}, 32'd5);
    checkOutput("mcount_hold", {16'b0, mispredictCount}, 32'd3);

    // Reset wins over a simultaneous taken update of entry 4.
    reset = 1'b1;
    applyStimulus(1'b1, 32'h10, 4'h0, 1'b0, 1'b1, 32'h0, 4'h0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h10, 4'h0);
    checkOutput("rst_prio_pred", {31'b0, predictTaken}, 32'd0);
    checkOutput("rst_prio_bcount", {16'b0, branchCount}, 32'd0);
    checkOutput("rst_prio_mcount", {16'b0, mispredictCount}, 32'd0);
    applyStimulus(1'b1, 32'h10, 4'h0, 1'b1, 1'b1, 32'h0, 4'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h10, 4'h0);
    checkOutput("rst_then_train", {31'b0, predictTaken}, 32'd1);

    // Count saturation: 65537 mispredicted branches in total.
    pulseReset();
    applyStimulus(1'b1, 32'h20, 4'h0, 1'b0, 1'b1, 32'h0, 4'h0);
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("bcount_fffe", {16'b0, branchCount}, 32'hfffe);
    checkOutput("mcount_fffe", {16'b0, mispredictCount}, 32'hfffe);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bcount_sat", {16'b0, branchCount}, 32'hffff);
    checkOutput("mcount_sat", {16'b0, mispredictCount}, 32'hffff);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
